// File: rtl/getir.sv
// Instruction fetch unit: credit-limited requests to L1I, in-order responses into a small head-registered buffer.
// Define GETIR_STATIK_TAHMIN_EN to build static backward-taken branch prediction.
module getir #(
  parameter logic [31:0] RESET_PS        = 32'h4000_0000,
  parameter int unsigned TAMPON_DERINLIK = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        l1b_istek_o,
  output logic [31:0] l1b_adres_o,
  input  logic        l1b_istek_hazir_i,
  input  logic        l1b_yanit_gecerli_i,
  input  logic [31:0] l1b_yanit_buyruk_i,
  input  logic        cek_bosalt_i,
  input  logic [31:0] cek_ps_i,
  input  logic        cek_duraklat_i,
  output logic [31:0] getir_buyruk_o,
  output logic [31:0] getir_ps_o,
  output logic        getir_gecerli_o,
  output logic        getir_atladi_o
);
  localparam int unsigned D    = TAMPON_DERINLIK;
  localparam int unsigned SW   = $clog2(TAMPON_DERINLIK) + 1;
  localparam logic [31:0] HIZA = 32'hFFFF_FFFC;

  logic [31:0]   ps_q, ps_d;
  logic [31:0]   buyruk_q [D];
  logic [31:0]   buyruk_d [D];
  logic [31:0]   bps_q [D];
  logic [31:0]   bps_d [D];
  logic [31:0]   psk_q [D];
  logic [31:0]   psk_d [D];
  logic [SW-1:0] dolu_q, dolu_d, canli_q, canli_d, dusur_q, dusur_d, bekleyen;
  logic [SW:0]   kredi;
  logic          yanit_var, yanit_canli, yaz, tahmin, kabul, cek;

  // canli: outstanding requests whose PC is queued in psk; dusur: requests whose responses are discarded
  assign bekleyen    = canli_q + dusur_q;
  assign kredi       = {1'b0, dolu_q} + {1'b0, bekleyen};
  assign yanit_var   = l1b_yanit_gecerli_i && (bekleyen != '0);
  assign yanit_canli = l1b_yanit_gecerli_i && (dusur_q == '0) && (canli_q != '0);
  assign yaz         = yanit_canli && !cek_bosalt_i;
  assign l1b_istek_o = !rst_i && !cek_bosalt_i && !tahmin && (kredi < (SW+1)'(D));
  assign kabul       = l1b_istek_o && l1b_istek_hazir_i;
  assign cek         = getir_gecerli_o && !cek_duraklat_i;

  assign l1b_adres_o     = ps_q;
  assign getir_buyruk_o  = buyruk_q[0];
  assign getir_ps_o      = bps_q[0];
  assign getir_gecerli_o = (dolu_q != '0);

`ifdef GETIR_STATIK_TAHMIN_EN
  logic        atladi_q [D];
  logic        atladi_d [D];
  logic [31:0] b_imm, hedef;
  assign b_imm  = {{20{l1b_yanit_buyruk_i[31]}}, l1b_yanit_buyruk_i[7],
                   l1b_yanit_buyruk_i[30:25], l1b_yanit_buyruk_i[11:8], 1'b0};
  assign tahmin = yaz && (l1b_yanit_buyruk_i[6:0] == 7'b1100011) && l1b_yanit_buyruk_i[31];
  assign hedef  = (psk_q[0] + b_imm) & HIZA;
  assign getir_atladi_o = atladi_q[0];
`else
  assign tahmin = 1'b0;
  assign getir_atladi_o = 1'b0;
`endif

  // Shift buffer with head at slot 0; a pop that empties it leaves slot 0 untouched so outputs hold
  always_comb begin
    buyruk_d = buyruk_q;
    bps_d    = bps_q;
`ifdef GETIR_STATIK_TAHMIN_EN
    atladi_d = atladi_q;
`endif
    dolu_d   = dolu_q;
    if (cek_bosalt_i) begin
      dolu_d = '0;
    end else begin
      if (cek) begin
        for (int unsigned i = 0; i + 1 < D; i++) begin
          if (i + 1 < 32'(dolu_q)) begin
            buyruk_d[i] = buyruk_q[i+1];
            bps_d[i]    = bps_q[i+1];
`ifdef GETIR_STATIK_TAHMIN_EN
            atladi_d[i] = atladi_q[i+1];
`endif
          end
        end
        dolu_d = dolu_q - SW'(1);
      end
      if (yaz) begin
        for (int unsigned i = 0; i < D; i++) begin
          if (i == 32'(dolu_d)) begin
            buyruk_d[i] = l1b_yanit_buyruk_i;
            bps_d[i]    = psk_q[0];
`ifdef GETIR_STATIK_TAHMIN_EN
            atladi_d[i] = tahmin;
`endif
          end
        end
        dolu_d = dolu_d + SW'(1);
      end
    end
  end

  always_comb begin
    psk_d   = psk_q;
    canli_d = canli_q;
    dusur_d = dusur_q;
    ps_d    = ps_q;
    if (cek_bosalt_i) begin
      canli_d = '0;
      dusur_d = bekleyen - (yanit_var ? SW'(1) : '0);
      ps_d    = cek_ps_i & HIZA;
    end else if (tahmin) begin
`ifdef GETIR_STATIK_TAHMIN_EN
      ps_d    = hedef;
`endif
      canli_d = '0;
      dusur_d = canli_q - SW'(1);
    end else begin
      if (l1b_yanit_gecerli_i && (dusur_q != '0)) begin
        dusur_d = dusur_q - SW'(1);
      end else if (yanit_canli) begin
        for (int unsigned i = 0; i + 1 < D; i++)
          if (i + 1 < 32'(canli_q)) psk_d[i] = psk_q[i+1];
        canli_d = canli_q - SW'(1);
      end
      if (kabul) begin
        for (int unsigned i = 0; i < D; i++)
          if (i == 32'(canli_d)) psk_d[i] = ps_q;
        canli_d = canli_d + SW'(1);
        ps_d    = ps_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_q    <= RESET_PS & HIZA;
      dolu_q  <= '0;
      canli_q <= '0;
      dusur_q <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        buyruk_q[i] <= '0;
        bps_q[i]    <= '0;
`ifdef GETIR_STATIK_TAHMIN_EN
        atladi_q[i] <= 1'b0;
`endif
      end
    end else begin
      ps_q     <= ps_d;
      dolu_q   <= dolu_d;
      canli_q  <= canli_d;
      dusur_q  <= dusur_d;
      buyruk_q <= buyruk_d;
      bps_q    <= bps_d;
`ifdef GETIR_STATIK_TAHMIN_EN
      atladi_q <= atladi_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    psk_q <= psk_d;
  end

endmodule

// File: doc/getir.md
GETIR -- requirements
Module: getir

Interface
REQ-001 Parameter RESET_PS, 32'h4000_0000, fetch address loaded on reset.
REQ-002 Parameter TAMPON_DERINLIK, 2, instruction buffer depth; legal values 2 or 4.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 l1b_istek_o  output  1  fetch request valid.
REQ-006 l1b_adres_o  output  32  fetch address, bits [1:0] always 0.
REQ-007 l1b_istek_hazir_i  input  1  memory accepts request this cycle.
REQ-008 l1b_yanit_gecerli_i  input  1  response valid; responses return in request order.
REQ-009 l1b_yanit_buyruk_i  input  32  returned instruction word.
REQ-010 cek_bosalt_i  input  1  pipeline flush / redirect.
REQ-011 cek_ps_i  input  32  redirect target, sampled when cek_bosalt_i=1.
REQ-012 cek_duraklat_i  input  1  downstream stall; the decode stage will not take the current output.
REQ-013 getir_buyruk_o  output  32  instruction at buffer head.
REQ-014 getir_ps_o  output  32  PC of getir_buyruk_o.
REQ-015 getir_gecerli_o  output  1  buffer head valid.
REQ-016 getir_atladi_o  output  1  head instruction was predicted taken.

Function
REQ-017 Request handshake: accepted on the cycle l1b_istek_o && l1b_istek_hazir_i; l1b_adres_o = ps_r; on acceptance ps_r <= ps_r + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-018 Credit rule: l1b_istek_o=1 only if (buffer occupancy + outstanding requests) < TAMPON_DERINLIK and cek_bosalt_i=0; buffer overflow is therefore impossible.
REQ-019 A valid response with drop count 0 is written to the buffer tail with its PC (PC FIFO held alongside the requests), atladi=0, and outstanding count decremented.
REQ-020 Outputs are driven directly from registered buffer head; pop on getir_gecerli_o && !cek_duraklat_i; fetch latency from response to getir_gecerli_o = 1 cycle.
REQ-021 Same-cycle push and pop are legal at any occupancy, including full; occupancy unchanged.
REQ-022 Empty buffer: getir_gecerli_o=0; getir_buyruk_o/ps_o/atladi_o hold their last values.
REQ-023 Flush (cek_bosalt_i=1): buffer emptied and getir_gecerli_o=0 next cycle; ps_r <= {cek_ps_i[31:2],2'b00}; no request issued that cycle; drop count <= outstanding requests not returned in that cycle; a response arriving in the flush cycle is discarded.
REQ-024 While drop count > 0 each response is discarded and decrements drop count; it frees credit but never enters the buffer.
REQ-025 Flush has priority over stall, push, pop and prediction in the same cycle.
REQ-026 A response with outstanding count and drop count both 0 is ignored; no counter wraps below 0.
REQ-027 Counters (occupancy, outstanding, drop) are log2(TAMPON_DERINLIK)+1 bits wide.

Reset
REQ-028 On rst_i=1 at a clock edge: ps_r=RESET_PS, buffer empty, outstanding=0, drop=0, l1b_istek_o=0, getir_gecerli_o=0, getir_atladi_o=0, getir_buyruk_o=0, getir_ps_o=0.
REQ-029 Reset mid-transaction abandons in-flight requests; responses in the first cycle after reset are ignored per REQ-026.
REQ-030 First request is issued the cycle after rst_i deasserts.

Configuration
REQ-031 Macro GETIR_STATIK_TAHMIN_EN enables static backward-taken branch prediction.
REQ-032 With it: a pushed word with opcode 7'b1100011 and imm[12]=1 gets atladi=1; in that cycle ps_r <= PC+B-imm, the drop count takes all outstanding requests, and no request is issued.
REQ-033 Without it: getir_atladi_o is constant 0 and no prediction logic is built; all other behaviour is identical.

Verification
REQ-034 Reset, hazir=1, response 1 cycle after each request -> addresses 0x4000_0000, 0x4000_0004, 0x4000_0008; getir_ps_o follows in order with gecerli=1.
REQ-035 cek_duraklat_i=1 for 5 cycles with TAMPON_DERINLIK=2 -> at most 2 requests outstanding or buffered; head holds 0x4000_0000; no word is lost after release.
REQ-036 Flush with cek_ps_i=0x8000_0003 and 2 requests outstanding -> next address 0x8000_0000; both late responses dropped; first delivered PC 0x8000_0000.
REQ-037 ps_r=0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-038 GETIR_STATIK_TAHMIN_EN, word 0xFE000EE3 (beq x0,x0,-4) at 0x4000_0010 -> atladi=1, next address 0x4000_000C, younger responses dropped; without the macro atladi=0 and the next address is 0x4000_0014.
